// File: rtl/fifo_arb_pkg.sv
// Shared types and elaboration helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Ceiling log2 with a floor of 1 bit so single-entry ranges still get a real vector.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request strictly after last_grant, wrapping modulo NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter driving the async FIFO write port; a burst starts only with room for MAX_BURST words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int RAM_ADDR_WIDTH = 5,
  parameter int WR_CNT_WIDTH   = RAM_ADDR_WIDTH + 1,
  parameter int MAX_BURST      = 8
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic [WR_CNT_WIDTH-1:0]       wr_data_count,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_active,
  output logic [clog2(NUM_REQ)-1:0]     grant_id
);

  localparam int ID_W       = clog2(NUM_REQ);
  localparam int CNT_W      = clog2(MAX_BURST + 1);
  localparam int FIFO_DEPTH = fifo_depth(RAM_ADDR_WIDTH);

  // Handshake: a word moves when req_valid[g] && req_ready[g] during BURST; ready never depends on valid.
  arb_state_t        state, state_next;
  logic [ID_W-1:0]   last_grant;
  logic [CNT_W-1:0]  burst_cnt;
  logic [WR_CNT_WIDTH:0] free;
  logic              space_ok;
  logic [ID_W-1:0]   pick;
  logic              any_req;
  logic              xfer;
  logic              burst_done;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (pick),
    .any_req    (any_req)
  );

  // One extra bit keeps the subtraction from wrapping.
  assign free     = (WR_CNT_WIDTH+1)'(FIFO_DEPTH) - {1'b0, wr_data_count};
  assign space_ok = free >= (WR_CNT_WIDTH+1)'(MAX_BURST);

  always_comb begin
    state_next   = state;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    xfer         = 1'b0;
    burst_done   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && space_ok) state_next = BURST;
      end
      BURST: begin
        req_ready[grant_id] = !fifo_full;
        fifo_wr_data        = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
        xfer                = req_valid[grant_id] && !fifo_full;
        fifo_wr_en          = xfer;
        // Last word and count limit on the same transfer collapse into one exit.
        burst_done = xfer && (req_last[grant_id] || burst_cnt == CNT_W'(MAX_BURST - 1));
        if (burst_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == BURST) begin
        grant_id  <= pick;
        burst_cnt <= '0;
      end
      if (xfer) burst_cnt <= burst_cnt + CNT_W'(1);
      if (burst_done) last_grant <= grant_id;
    end
  end

  assign grant_active = (state == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: inputs change just after posedge, outputs sampled on negedge.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int AW      = 5;
  localparam int CW      = AW + 1;
  localparam int MB      = 8;

  logic                  wr_clk;
  logic                  wr_rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  fifo_full;
  logic [CW-1:0]         wr_data_count;
  logic                  fifo_wr_en;
  logic [DW-1:0]         fifo_wr_data;
  logic                  grant_active;
  logic [1:0]            grant_id;

  fifo_wr_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .DATA_WIDTH     (DW),
    .RAM_ADDR_WIDTH (AW),
    .WR_CNT_WIDTH   (CW),
    .MAX_BURST      (MB)
  ) dut (
    .wr_clk        (wr_clk),
    .wr_rst_n      (wr_rst_n),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .wr_data_count (wr_data_count),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_data  (fifo_wr_data),
    .grant_active  (grant_active),
    .grant_id      (grant_id)
  );

  // clock / reset
  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic settle();
    @(negedge wr_clk);
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  function automatic logic [DW-1:0] data_of(input int g, input int n);
    return DW'(g * 64 + n);
  endfunction

  // scoreboard: every FIFO write must match the next expected word
  always @(negedge wr_clk) begin
    if (fifo_wr_en) begin
      check("wr_while_full", 32'(fifo_full), 32'd0);
      check("exp_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("wr_data", 32'(fifo_wr_data), 32'(exp_q.pop_front()));
    end
  end

  int seq[NUM_REQ];
  int order[5] = '{0, 1, 2, 3, 0};
  logic [DW-1:0] bw[6] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};

  initial begin
    wr_rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    fifo_full = 1'b0; wr_data_count = '0;

    settle();
    check("rst_active", 32'(grant_active), 0);
    check("rst_id", 32'(grant_id), 0);
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_data", 32'(fifo_wr_data), 0);
    tick();
    wr_rst_n = 1'b1;

    // single requester, 3-word packet
    req_valid = 4'b0100; set_word(2, 8'hA1); exp_q.push_back(8'hA1);
    settle();
    check("t1_idle_ready", 32'(req_ready), 0);
    check("t1_idle_active", 32'(grant_active), 0);
    tick();
    settle();
    check("t1_grant_id", 32'(grant_id), 2);
    check("t1_ready", 32'(req_ready), 32'b0100);
    check("t1_wr_en0", 32'(fifo_wr_en), 1);
    tick();
    set_word(2, 8'hA2); exp_q.push_back(8'hA2);
    settle();
    check("t1_wr_en1", 32'(fifo_wr_en), 1);
    tick();
    set_word(2, 8'hA3); req_last = 4'b0100; exp_q.push_back(8'hA3);
    settle();
    check("t1_wr_en2", 32'(fifo_wr_en), 1);
    check("t1_active_last", 32'(grant_active), 1);
    tick();
    req_valid = '0; req_last = '0;
    settle();
    check("t1_exit_active", 32'(grant_active), 0);
    check("t1_exit_wr_en", 32'(fifo_wr_en), 0);
    check("t1_exit_data", 32'(fifo_wr_data), 0);
    tick();

    // round-robin fairness from reset priority
    wr_rst_n = 1'b0; #1; wr_rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      seq[i] = 0;
      set_word(i, data_of(i, 0));
    end
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("t2_gap_active", 32'(grant_active), 0);
      check("t2_gap_wr_en", 32'(fifo_wr_en), 0);
      tick();
      for (int w = 0; w < MB; w++) begin
        exp_q.push_back(data_of(order[k], seq[order[k]]));
        settle();
        check("t2_grant_id", 32'(grant_id), 32'(order[k]));
        check("t2_wr_en", 32'(fifo_wr_en), 1);
        tick();
        seq[order[k]]++;
        set_word(order[k], data_of(order[k], seq[order[k]]));
      end
    end
    req_valid = '0;
    settle();
    check("t2_end_active", 32'(grant_active), 0);
    tick();

    // space gating: free 7 blocks, free 8 admits
    req_valid = 4'b0010; req_last = 4'b0010; set_word(1, 8'h51); wr_data_count = 6'd25;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t3_blocked_active", 32'(grant_active), 0);
      check("t3_blocked_ready", 32'(req_ready), 0);
      tick();
    end
    wr_data_count = 6'd24; exp_q.push_back(8'h51);
    settle();
    check("t3_pre_grant", 32'(grant_active), 0);
    tick();
    settle();
    check("t3_grant_active", 32'(grant_active), 1);
    check("t3_grant_id", 32'(grant_id), 1);
    check("t3_wr_en", 32'(fifo_wr_en), 1);
    tick();
    req_valid = '0; req_last = '0; wr_data_count = '0;
    settle();
    check("t3_exit", 32'(grant_active), 0);
    tick();

    // full for 3 cycles mid-burst
    req_valid = 4'b1000; set_word(3, bw[0]); exp_q.push_back(bw[0]);
    settle();
    tick();
    settle();
    check("t4_grant_id", 32'(grant_id), 3);
    check("t4_wr_en0", 32'(fifo_wr_en), 1);
    tick();
    set_word(3, bw[1]); exp_q.push_back(bw[1]);
    settle();
    check("t4_wr_en1", 32'(fifo_wr_en), 1);
    tick();
    set_word(3, bw[2]); fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t4_full_ready", 32'(req_ready), 0);
      check("t4_full_wr_en", 32'(fifo_wr_en), 0);
      check("t4_full_active", 32'(grant_active), 1);
      tick();
    end
    fifo_full = 1'b0;
    for (int i = 2; i < 6; i++) begin
      set_word(3, bw[i]); req_last = (i == 5) ? 4'b1000 : 4'b0000; exp_q.push_back(bw[i]);
      settle();
      check("t4_resume_wr_en", 32'(fifo_wr_en), 1);
      check("t4_resume_ready", 32'(req_ready), 32'b1000);
      tick();
    end
    req_valid = '0; req_last = '0;
    settle();
    check("t4_exit", 32'(grant_active), 0);
    tick();

    // valid gap holds grant; last on word 8 exits once
    req_valid = 4'b0011; req_last = 4'b0010; set_word(1, 8'hE0);
    settle();
    tick();
    for (int i = 0; i < MB; i++) begin
      if (i == 3) begin
        req_valid[0] = 1'b0;
        for (int j = 0; j < 2; j++) begin
          settle();
          check("t5_gap_id", 32'(grant_id), 0);
          check("t5_gap_wr_en", 32'(fifo_wr_en), 0);
          check("t5_gap_ready", 32'(req_ready), 32'b0001);
          check("t5_gap_active", 32'(grant_active), 1);
          tick();
        end
        req_valid[0] = 1'b1;
      end
      set_word(0, DW'(8'hC0 + i)); req_last[0] = (i == MB - 1); exp_q.push_back(DW'(8'hC0 + i));
      settle();
      check("t5_id", 32'(grant_id), 0);
      check("t5_wr_en", 32'(fifo_wr_en), 1);
      tick();
    end
    req_last[0] = 1'b0; set_word(0, 8'h99); exp_q.push_back(8'hE0);
    settle();
    check("t5_single_exit", 32'(grant_active), 0);
    tick();
    settle();
    check("t5_next_id", 32'(grant_id), 1);
    check("t5_next_wr_en", 32'(fifo_wr_en), 1);
    tick();
    req_valid = '0; req_last = '0;
    settle();
    check("t5_exit", 32'(grant_active), 0);
    tick();

    // asynchronous reset mid-burst
    req_valid = 4'b0100; set_word(2, 8'hF0); exp_q.push_back(8'hF0);
    settle();
    tick();
    settle();
    check("t6_grant_id", 32'(grant_id), 2);
    tick();
    set_word(2, 8'hF1); exp_q.push_back(8'hF1);
    settle();
    check("t6_wr_en1", 32'(fifo_wr_en), 1);
    tick();
    set_word(2, 8'hF2);
    wr_rst_n = 1'b0;
    #1;
    check("t6_rst_active", 32'(grant_active), 0);
    check("t6_rst_wr_en", 32'(fifo_wr_en), 0);
    check("t6_rst_ready", 32'(req_ready), 0);
    check("t6_rst_data", 32'(fifo_wr_data), 0);
    check("t6_rst_id", 32'(grant_id), 0);
    settle();
    tick();
    wr_rst_n = 1'b1;
    req_valid = 4'b1101; req_last = 4'b0001; set_word(0, 8'h70); exp_q.push_back(8'h70);
    settle();
    check("t6_idle", 32'(grant_active), 0);
    tick();
    settle();
    check("t6_prio0", 32'(grant_id), 0);
    check("t6_wr_en", 32'(fifo_wr_en), 1);
    tick();
    req_valid = '0; req_last = '0;
    settle();
    check("q_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
